// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RV32I pipeline: control word, ALU and
// result-select codes, forwarding selects.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    // All-zero word is a bubble: no writes, no control transfer, ALU add.
    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
    } ctrl_t;

    // A later stage supplies a source only if it writes a non-x0 register.
    function automatic logic fwd_hit(input logic we, input logic [REGW_DEF-1:0] rd,
                                     input logic [REGW_DEF-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/forwarding inputs and execute-stage outputs of the ID/EX stage.
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
);
    ctrl_t            CtrlD;
    logic [XLEN-1:0]  RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [REGW-1:0]  Rs1D, Rs2D, RdD;
    logic [XLEN-1:0]  ALUResultM, ResultW;
    logic [REGW-1:0]  RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             ZeroE;

    ctrl_t            CtrlE;
    logic [XLEN-1:0]  SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE;
    logic [REGW-1:0]  RdE;
    logic             PCSrcE, StallF, StallD, FlushD;

    modport slave (
        input  CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, ZeroE,
        output CtrlE, SrcAE, SrcBE, WriteDataE, RdE, PCPlus4E, PCTargetE,
               PCSrcE, StallF, StallD, FlushD
    );

    modport master (
        output CtrlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
               ALUResultM, ResultW, RdM, RdW, RegWriteM, RegWriteW, ZeroE,
        input  CtrlE, SrcAE, SrcBE, WriteDataE, RdE, PCPlus4E, PCTargetE,
               PCSrcE, StallF, StallD, FlushD
    );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational hazard logic: MEM/WB forwarding selects, load-use stall and
// front-end/E-stage flush requests.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic [REGW_DEF-1:0] rs1_d_i,
    input  logic [REGW_DEF-1:0] rs2_d_i,
    input  logic [REGW_DEF-1:0] rs1_e_i,
    input  logic [REGW_DEF-1:0] rs2_e_i,
    input  logic [REGW_DEF-1:0] rd_e_i,
    input  logic [1:0]          res_src_e_i,
    input  logic [REGW_DEF-1:0] rd_m_i,
    input  logic [REGW_DEF-1:0] rd_w_i,
    input  logic                reg_write_m_i,
    input  logic                reg_write_w_i,
    input  logic                pc_src_e_i,
    output fwd_t                fwd_a_o,
    output fwd_t                fwd_b_o,
    output logic                stall_f_o,
    output logic                stall_d_o,
    output logic                flush_d_o,
    output logic                flush_e_o
);
    logic lw_stall;

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        fwd_a_o = FWD_RF;
        fwd_b_o = FWD_RF;
        if (fwd_hit(reg_write_m_i, rd_m_i, rs1_e_i))      fwd_a_o = FWD_M;
        else if (fwd_hit(reg_write_w_i, rd_w_i, rs1_e_i)) fwd_a_o = FWD_W;
        if (fwd_hit(reg_write_m_i, rd_m_i, rs2_e_i))      fwd_b_o = FWD_M;
        else if (fwd_hit(reg_write_w_i, rd_w_i, rs2_e_i)) fwd_b_o = FWD_W;
    end

    assign lw_stall  = (res_src_e_i == RES_MEM) && (rd_e_i != '0) &&
                       ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
    assign stall_f_o = lw_stall;
    assign stall_d_o = lw_stall;
    assign flush_d_o = pc_src_e_i;
    assign flush_e_o = lw_stall | pc_src_e_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, branch resolution and
// hazard-driven stall/flush of the front end.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
)(
    input logic            clk,
    input logic            reset,
    id_ex_stage_if.slave   bus
);
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d;
    logic [REGW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

    fwd_t            fwd_a, fwd_b;
    logic            flush_e, pc_src;
    logic [XLEN-1:0] src_a, write_data;

    assign pc_src = ctrl_q.Jump | (ctrl_q.Branch & bus.ZeroE);

    hazard_unit u_hazard (
        .rs1_d_i       (bus.Rs1D),
        .rs2_d_i       (bus.Rs2D),
        .rs1_e_i       (rs1_q),
        .rs2_e_i       (rs2_q),
        .rd_e_i        (rd_q),
        .res_src_e_i   (ctrl_q.ResultSrc),
        .rd_m_i        (bus.RdM),
        .rd_w_i        (bus.RdW),
        .reg_write_m_i (bus.RegWriteM),
        .reg_write_w_i (bus.RegWriteW),
        .pc_src_e_i    (pc_src),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .stall_f_o     (bus.StallF),
        .stall_d_o     (bus.StallD),
        .flush_d_o     (bus.FlushD),
        .flush_e_o     (flush_e)
    );

    // NOTE: every _d gets its default first, so no path through this block can infer a latch.
    always_comb begin
        ctrl_d = bus.CtrlD;
        rd1_d  = bus.RD1D;
        rd2_d  = bus.RD2D;
        imm_d  = bus.ImmExtD;
        pc_d   = bus.PCD;
        pc4_d  = bus.PCPlus4D;
        rs1_d  = bus.Rs1D;
        rs2_d  = bus.Rs2D;
        rd_d   = bus.RdD;
        if (flush_e) begin
            ctrl_d = '0;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            pc_d   = '0;
            pc4_d  = '0;
            rs1_d  = '0;
            rs2_d  = '0;
            rd_d   = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so all E registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            pc4_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            pc4_q  <= pc4_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
        end
    end

    always_comb begin
        unique case (fwd_a)
            FWD_M:   src_a = bus.ALUResultM;
            FWD_W:   src_a = bus.ResultW;
            default: src_a = rd1_q;
        endcase
        unique case (fwd_b)
            FWD_M:   write_data = bus.ALUResultM;
            FWD_W:   write_data = bus.ResultW;
            default: write_data = rd2_q;
        endcase
    end

    assign bus.CtrlE      = ctrl_q;
    assign bus.SrcAE      = src_a;
    assign bus.WriteDataE = write_data;
    assign bus.SrcBE      = ctrl_q.ALUSrc ? imm_q : write_data;
    assign bus.RdE        = rd_q;
    assign bus.PCPlus4E   = pc4_q;
    assign bus.PCTargetE  = pc_q + imm_q;
    assign bus.PCSrcE     = pc_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios
// followed by random traffic against a behavioural model of the E stage.
module tb_id_ex_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction currently held in E.
    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
    } e_t;
    e_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                 input logic j, input logic b, input logic [2:0] alu,
                                 input logic src);
        ctrl_t c;
        c.RegWrite = rw; c.ResultSrc = rs; c.MemWrite = mw; c.Jump = j;
        c.Branch = b; c.ALUControl = alu; c.ALUSrc = src;
        return c;
    endfunction

    function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf);
        if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return bus.ALUResultM;
        if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return bus.ResultW;
        return rf;
    endfunction

    function automatic logic model_lw();
        return m.ctrl.ResultSrc == RES_MEM && m.rd != 0 &&
               (bus.Rs1D == m.rd || bus.Rs2D == m.rd);
    endfunction

    function automatic logic model_pcsrc();
        return m.ctrl.Jump || (m.ctrl.Branch && bus.ZeroE);
    endfunction

    task automatic set_d(input ctrl_t c, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pc);
        bus.CtrlD = c; bus.Rs1D = rs1; bus.Rs2D = rs2; bus.RdD = rd;
        bus.RD1D = rd1; bus.RD2D = rd2; bus.ImmExtD = imm;
        bus.PCD = pc; bus.PCPlus4D = pc + 32'd4;
    endtask

    task automatic set_fwd(input logic [4:0] rdm, input logic rwm, input logic [31:0] alum,
                           input logic [4:0] rdw, input logic rww, input logic [31:0] resw);
        bus.RdM = rdm; bus.RegWriteM = rwm; bus.ALUResultM = alum;
        bus.RdW = rdw; bus.RegWriteW = rww; bus.ResultW = resw;
        bus.ZeroE = 1'b0;
    endtask

    // Every output compared with what the model predicts for the current inputs.
    task automatic check_all();
        logic [31:0] exp_a, exp_wd, exp_b;
        logic        lw, pcs;
        #1;
        exp_a  = fwd_val(m.rs1, m.rd1);
        exp_wd = fwd_val(m.rs2, m.rd2);
        exp_b  = m.ctrl.ALUSrc ? m.imm : exp_wd;
        lw     = model_lw();
        pcs    = model_pcsrc();
        check("CtrlE",      32'(bus.CtrlE),      32'(m.ctrl));
        check("SrcAE",      bus.SrcAE,           exp_a);
        check("SrcBE",      bus.SrcBE,           exp_b);
        check("WriteDataE", bus.WriteDataE,      exp_wd);
        check("RdE",        32'(bus.RdE),        32'(m.rd));
        check("PCPlus4E",   bus.PCPlus4E,        m.pc4);
        check("PCTargetE",  bus.PCTargetE,       m.pc + m.imm);
        check("PCSrcE",     32'(bus.PCSrcE),     32'(pcs));
        check("StallF",     32'(bus.StallF),     32'(lw));
        check("StallD",     32'(bus.StallD),     32'(lw));
        check("FlushD",     32'(bus.FlushD),     32'(pcs));
        check("stall_vs_redirect", 32'(bus.StallF & bus.PCSrcE), 32'd0);
    endtask

    // One clock edge; the model loads D or a bubble by the flush rule.
    task automatic tick();
        e_t nxt;
        if (model_lw() || model_pcsrc()) begin
            nxt = '0;
        end else begin
            nxt.ctrl = bus.CtrlD; nxt.rd1 = bus.RD1D; nxt.rd2 = bus.RD2D;
            nxt.imm = bus.ImmExtD; nxt.pc = bus.PCD; nxt.pc4 = bus.PCPlus4D;
            nxt.rs1 = bus.Rs1D; nxt.rs2 = bus.Rs2D; nxt.rd = bus.RdD;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic rand_ctrl(output ctrl_t c);
        logic [2:0] alu_codes [5];
        alu_codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
        case ($urandom_range(0, 5))
            0:       c = mk(1, RES_ALU, 0, 0, 0, alu_codes[$urandom_range(0, 4)], 0);
            1:       c = mk(1, RES_ALU, 0, 0, 0, alu_codes[$urandom_range(0, 4)], 1);
            2:       c = mk(1, RES_MEM, 0, 0, 0, ALU_ADD, 1);
            3:       c = mk(0, RES_ALU, 1, 0, 0, ALU_ADD, 1);
            4:       c = mk(0, RES_ALU, 0, 0, 1, ALU_SUB, 0);
            default: c = mk(1, RES_PC4, 0, 1, 0, ALU_ADD, 0);
        endcase
    endtask

    initial begin
        ctrl_t c;
        m = '0;
        reset = 1'b1;
        set_d('0, 0, 0, 0, 0, 0, 0, 0);
        bus.PCPlus4D = '0;
        set_fwd(0, 0, 0, 0, 0, 0);

        // Reset state, then the cycle after release.
        check_all();
        @(negedge clk);
        reset = 1'b0;
        check_all();
        tick();
        check_all();

        // MEM has priority over WB on operand A; WB used when MEM not writing.
        set_d(mk(1, RES_ALU, 0, 0, 0, ALU_ADD, 0), 5, 7, 8, 32'h3, 32'h4, 0, 32'h40);
        tick();
        set_fwd(5, 1, 32'h11, 5, 1, 32'h22);
        check_all();
        check("fwd_mem_prio", bus.SrcAE, 32'h11);
        bus.RegWriteM = 1'b0;
        check_all();
        check("fwd_wb", bus.SrcAE, 32'h22);

        // x0 never forwards.
        set_d(mk(1, RES_ALU, 0, 0, 0, ALU_ADD, 0), 0, 0, 9, 0, 0, 0, 32'h44);
        tick();
        set_fwd(0, 1, 32'hDEAD, 0, 1, 32'hBEEF);
        check_all();
        check("no_x0_fwd", bus.SrcAE, 32'h0);

        // Immediate operand B while store data is forwarded from MEM.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(mk(0, RES_ALU, 1, 0, 0, ALU_ADD, 1), 2, 9, 0, 32'h10, 32'h1, 32'h7FF, 32'h48);
        tick();
        set_fwd(9, 1, 32'h55, 0, 0, 0);
        check_all();
        check("alusrc_imm", bus.SrcBE, 32'h7FF);
        check("store_fwd_m", bus.WriteDataE, 32'h55);

        // Load-use: lw x6 in E, consumer reads x6 as rs2.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(mk(1, RES_MEM, 0, 0, 0, ALU_ADD, 1), 1, 0, 6, 32'h100, 0, 32'h8, 32'h50);
        tick();
        set_d(mk(1, RES_ALU, 0, 0, 0, ALU_ADD, 0), 1, 6, 7, 32'h2, 32'h0BAD, 0, 32'h54);
        check_all();
        check("lw_stallF", 32'(bus.StallF), 32'd1);
        check("lw_stallD", 32'(bus.StallD), 32'd1);
        tick();
        check_all();
        check("lw_bubble_ctrl", 32'(bus.CtrlE), 32'd0);
        check("lw_bubble_rd", 32'(bus.RdE), 32'd0);
        tick();
        set_fwd(0, 0, 0, 6, 1, 32'hCAFE);
        check_all();
        check("lw_dep_fwd_w", bus.WriteDataE, 32'hCAFE);

        // Branch with negative offset: taken and not taken.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(mk(0, RES_ALU, 0, 0, 1, ALU_SUB, 0), 3, 4, 0, 0, 0, 32'hFFFF_FFF0, 32'h100);
        tick();
        set_d(mk(1, RES_ALU, 0, 0, 0, ALU_ADD, 0), 1, 2, 3, 1, 2, 0, 32'h104);
        check_all();
        check("br_ntaken_pcsrc", 32'(bus.PCSrcE), 32'd0);
        check("br_ntaken_flush", 32'(bus.FlushD), 32'd0);
        bus.ZeroE = 1'b1;
        check_all();
        check("br_target_wrap", bus.PCTargetE, 32'h0000_00F0);
        check("br_taken_pcsrc", 32'(bus.PCSrcE), 32'd1);
        check("br_taken_flush", 32'(bus.FlushD), 32'd1);
        tick();
        check_all();
        check("br_flush_e", 32'(bus.CtrlE), 32'd0);

        // Asynchronous reset with a live ADD in E.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_d(mk(1, RES_ALU, 0, 0, 0, ALU_ADD, 0), 1, 2, 3, 32'h7, 32'h9, 0, 32'h200);
        tick();
        check("add_in_e", 32'(bus.RdE), 32'd3);
        #2;
        reset = 1'b1;
        m = '0;
        #1;
        check("rst_ctrl", 32'(bus.CtrlE), 32'd0);
        check("rst_rd", 32'(bus.RdE), 32'd0);
        check("rst_pcsrc", 32'(bus.PCSrcE), 32'd0);
        check("rst_stallf", 32'(bus.StallF), 32'd0);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        tick();
        check_all();
        check("post_rst_load", 32'(bus.RdE), 32'd3);

        // Random traffic with small register indices to provoke hazards.
        for (int i = 0; i < 300; i++) begin
            rand_ctrl(c);
            set_d(c, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
            set_fwd(5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                    5'($urandom_range(0, 7)), 1'($urandom), $urandom);
            bus.ZeroE = 1'($urandom);
            check_all();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-issue logic that feeds the execute-stage ALU. It registers the decoded instruction, forwards operands from MEM/WB, and detects load-use hazards. It also takes ZeroE back from the ALU to resolve branches and jumps, and drives stall/flush to the front end. It sits between the decode stage and the ALU/EX-MEM register of the 5-stage RV32I pipeline.

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
CtrlD  in  ctrl_t (10)  decoded control: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc
RD1D  in  XLEN  register-file read port 1
RD2D  in  XLEN  register-file read port 2
ImmExtD  in  XLEN  sign-extended immediate
PCD  in  XLEN  decode-stage PC
PCPlus4D  in  XLEN  PCD+4
Rs1D  in  REGW  source 1 index
Rs2D  in  REGW  source 2 index
RdD  in  REGW  destination index
ALUResultM  in  XLEN  MEM-stage result, forwarding source
ResultW  in  XLEN  WB-stage result, forwarding source
RdM  in  REGW  MEM-stage destination
RdW  in  REGW  WB-stage destination
RegWriteM  in  1  MEM-stage write enable
RegWriteW  in  1  WB-stage write enable
ZeroE  in  1  ALU zero flag for the current E instruction
CtrlE  out  ctrl_t  registered control; ALUControlE field drives the ALU
SrcAE  out  XLEN  ALU operand a, forwarded RD1
SrcBE  out  XLEN  ALU operand b: ImmExtE if ALUSrc, else WriteDataE
WriteDataE  out  XLEN  forwarded RD2, store data
RdE  out  REGW  registered destination
PCPlus4E  out  XLEN  registered PC+4
PCTargetE  out  XLEN  PCE+ImmExtE
PCSrcE  out  1  redirect fetch to PCTargetE
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register

Behaviour:
- E register set: CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE.
- Async reset: all E registers are 0. The result is a bubble: no RegWrite, no MemWrite, no Jump/Branch, ALUControl=ADD. All outputs are 0 while reset is held and in the cycle after release, provided the forwarding inputs are also 0.
- On each clk edge: if FlushE, load all zeros (bubble); otherwise load the D-stage values. There is no E-stage stall, and E always advances.
- FlushE = lwStall | PCSrcE.
- lwStall = (CtrlE.ResultSrc==RES_MEM) & (RdE!=0) & (Rs1D==RdE | Rs2D==RdE).
- StallF = StallD = lwStall. FlushD = PCSrcE.
- ForwardA:
  - MEM forward if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else WB forward if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else RD1E.
  - MEM has priority over WB. x0 never forwards.
- ForwardB: same rule using Rs2E and RD2E.
- SrcAE, WriteDataE and SrcBE are combinational from the registers and forwarding inputs. Latency is 1 cycle from D inputs to E outputs.
- PCSrcE = CtrlE.Jump | (CtrlE.Branch & ZeroE). This path is combinational and must not loop: ZeroE depends only on SrcAE/SrcBE.
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN (wrap-around, carry discarded).
- lwStall and PCSrcE cannot both be 1, because a load never carries Jump/Branch. No priority logic is needed, but the bench asserts the exclusion.
- A bubble in E never creates a hazard: RdE=0 and ResultSrc=RES_ALU.
- Reset asserted mid-operation clears E immediately (asynchronously). In-flight D contents are discarded only by the front end's own reset.

Decomposition:
- riscv_pkg holds:
  - ctrl_t packed struct.
  - ALU codes: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
  - ResultSrc codes: RES_ALU=00, RES_MEM=01, RES_PC4=10.
  - fwd_t: FWD_RF=00, FWD_W=01, FWD_M=10.
- Sub-module hazard_unit: combinational forwarding selects plus lwStall/StallF/StallD/FlushD/FlushE. The E registers and operand muxes stay in id_ex_stage.

Test Plan:
- Reset mid-stream with a valid ADD in E -> immediately CtrlE=0, RdE=0, PCSrcE=0, StallF=0; after release, the first edge loads D normally.
- RdM=5, RegWriteM=1, ALUResultM=0x11; RdW=5, RegWriteW=1, ResultW=0x22; Rs1E=5, RD1E=0x3 -> SrcAE=0x11 (MEM priority). With RegWriteM=0 -> SrcAE=0x22.
- RdM=0, RegWriteM=1, ALUResultM=0xDEAD, Rs1E=0, RD1E=0 -> SrcAE=0 (no x0 forward).
- lw x6 in E (ResultSrc=01, RdE=6), Rs2D=6 in D -> StallF=StallD=1. Next edge: CtrlE=0, RdE=0. The following edge loads the dependent instruction, which then sees ForwardB=FWD_W with WriteDataE=ResultW.
- beq in E, ZeroE=1, PCE=0x100, ImmExtE=0xFFFFFFF0 -> PCTargetE=0xF0, PCSrcE=1, FlushD=1; next CtrlE=0. With ZeroE=0 -> PCSrcE=0 and no flush.
- ALUSrc=1, ImmExtD=0x7FF, RD2 forwarded from M=0x55 -> SrcBE=0x7FF, WriteDataE=0x55.
